// File: rtl/program_loader.sv
// rtl/program_loader.sv - Boot loader: byte stream -> instruction memory writes, then core release.
// Header is a 16-bit LE word count; payload words are 32-bit LE.
module program_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  start,
    output logic                  loading,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        LOAD,
        FLUSH,
        RUN,
        ERR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t      state;
    state_t      next_state;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [16:0] word_idx;
    logic [23:0] assembly;
    logic        accept;
    logic [15:0] hdr_n;
    logic        word_last;

    assign accept    = rx_valid & rx_ready;
    assign hdr_n     = {rx_data, count[7:0]};
    assign word_last = (word_idx + 17'd1) == {1'b0, count};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = HDR0;
            HDR0: begin
                if (accept) begin
                    next_state = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    if (hdr_n == 16'd0) begin
                        next_state = FLUSH;
                    end else if ({1'b0, hdr_n} > CAPACITY) begin
                        next_state = ERR;
                    end else begin
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept && byte_idx == 2'd3 && word_last) begin
                    next_state = FLUSH;
                end
            end
            FLUSH:   next_state = RUN;
            RUN:     next_state = RUN;
            ERR:     next_state = ERR;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            start      <= 1'b0;
            loading    <= 1'b0;
            error      <= 1'b0;
            count      <= 16'd0;
            byte_idx   <= 2'd0;
            word_idx   <= 17'd0;
            assembly   <= 24'd0;
        end else begin
            rx_ready  <= (next_state == HDR0) || (next_state == HDR1) || (next_state == LOAD);
            loading   <= (next_state == HDR0) || (next_state == HDR1) ||
                         (next_state == LOAD) || (next_state == FLUSH);
            cpu_reset <= (next_state != RUN);
            start     <= (next_state == RUN);
            error     <= (next_state == ERR);
            imem_we   <= 1'b0;

            if (state == HDR0 && accept) begin
                count[7:0] <= rx_data;
            end

            if (state == HDR1 && accept) begin
                count[15:8] <= rx_data;
                byte_idx    <= 2'd0;
                word_idx    <= 17'd0;
            end

            if (state == LOAD && accept) begin
                case (byte_idx)
                    2'd0: assembly[7:0]   <= rx_data;
                    2'd1: assembly[15:8]  <= rx_data;
                    2'd2: assembly[23:16] <= rx_data;
                    default: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                        imem_wdata <= {rx_data, assembly};
                        word_idx   <= word_idx + 17'd1;
                    end
                endcase
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - Directed self-checking bench for program_loader.
module tb_program_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          start;
    logic          loading;
    logic          error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .start(start),
        .loading(loading), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        rx_data = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
            if (ok) break;
        end
        #1;
        rx_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_byte timeout: rx_ready 0 expected 1");
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, " imem_we"}, 32'(imem_we), 32'd0);
        chk({tag, " imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, " imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, " cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, " start"}, 32'(start), 32'd0);
        chk({tag, " loading"}, 32'(loading), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
    endtask

    task automatic send_basic(input int maxgap);
        logic [7:0] s[10];
        s = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int i = 0; i < 10; i++) send_byte(s[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    initial begin
        vecs[0] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
        vecs[3] = '{8'h01, 8'h00, 8'h00, 8'h80, 32'h80000001};
        vecs[4] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};

        // Reset state
        reset = 1'b1;
        #2;
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic load, back-to-back bytes
        send_basic(0);
        @(negedge clk);
        chk("flush imem_we", 32'(imem_we), 32'd1);
        chk("flush loading", 32'(loading), 32'd1);
        chk("flush start", 32'(start), 32'd0);
        chk("flush rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        chk("run start", 32'(start), 32'd1);
        chk("run cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run loading", 32'(loading), 32'd0);
        chk("run rx_ready", 32'(rx_ready), 32'd0);
        chk("basic writes", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("basic addr0", wr_addr[0], 32'd0);
            chk("basic data0", wr_data[0], 32'hDEADBEEF);
            chk("basic addr1", wr_addr[1], 32'd1);
            chk("basic data1", wr_data[1], 32'h01020304);
            chk("basic spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
        end

        // Post-RUN traffic is ignored
        #1;
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("postrun writes", 32'(wr_addr.size()), 32'd2);
        chk("postrun rx_ready", 32'(rx_ready), 32'd0);
        chk("postrun start", 32'(start), 32'd1);

        // Stalled stream
        do_reset();
        send_basic(5);
        repeat (3) @(negedge clk);
        chk("stall writes", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("stall addr0", wr_addr[0], 32'd0);
            chk("stall data0", wr_data[0], 32'hDEADBEEF);
            chk("stall addr1", wr_addr[1], 32'd1);
            chk("stall data1", wr_data[1], 32'h01020304);
        end
        chk("stall start", 32'(start), 32'd1);

        // Single-word vector table
        for (int v = 0; v < 5; v++) begin
            do_reset();
            send_byte(8'h01, 0);
            send_byte(8'h00, 0);
            send_byte(vecs[v].b0, 0);
            send_byte(vecs[v].b1, 1);
            send_byte(vecs[v].b2, 0);
            send_byte(vecs[v].b3, 2);
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d writes", v), 32'(wr_addr.size()), 32'd1);
            if (wr_addr.size() == 1) begin
                chk($sformatf("vec%0d addr", v), wr_addr[0], 32'd0);
                chk($sformatf("vec%0d data", v), wr_data[0], vecs[v].exp);
            end
            chk($sformatf("vec%0d start", v), 32'(start), 32'd1);
        end

        // Zero count
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("zero flush loading", 32'(loading), 32'd1);
        chk("zero flush start", 32'(start), 32'd0);
        @(negedge clk);
        chk("zero run start", 32'(start), 32'd1);
        chk("zero writes", 32'(wr_addr.size()), 32'd0);

        // Oversize header N=1025
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        #1;
        rx_data = 8'h5C;
        rx_valid = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("oversize error", 32'(error), 32'd1);
        chk("oversize rx_ready", 32'(rx_ready), 32'd0);
        chk("oversize cpu_reset", 32'(cpu_reset), 32'd1);
        chk("oversize start", 32'(start), 32'd0);
        chk("oversize loading", 32'(loading), 32'd0);
        chk("oversize writes", 32'(wr_addr.size()), 32'd0);

        // Mid-load reset, then fresh stream
        do_reset();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 0);
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        repeat (2) @(negedge clk);
        chk("fresh writes", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("fresh addr", wr_addr[0], 32'd0);
            chk("fresh data", wr_data[0], 32'h44332211);
        end
        chk("fresh start", 32'(start), 32'd1);

        // Boundary N=1024 fills the whole memory
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int w = 0; w < 1024; w++) begin
            send_byte(8'(w), 0);
            send_byte(8'(w >> 8), 0);
            send_byte(8'hC3, 0);
            send_byte(8'(w ^ 8'h5A), 0);
        end
        repeat (2) @(negedge clk);
        chk("full writes", 32'(wr_addr.size()), 32'd1024);
        chk("full error", 32'(error), 32'd0);
        chk("full start", 32'(start), 32'd1);
        if (wr_addr.size() == 1024) begin
            chk("full last addr", wr_addr[1023], 32'd1023);
            for (int w = 0; w < 1024; w++) begin
                logic [31:0] e;
                e = {8'(w ^ 8'h5A), 8'hC3, 8'(w >> 8), 8'(w)};
                if (wr_addr[w] != 32'(w) || wr_data[w] != e) begin
                    chk($sformatf("full addr%0d", w), wr_addr[w], 32'(w));
                    chk($sformatf("full data%0d", w), wr_data[w], e);
                end
            end
            chk("full data0", wr_data[0], 32'h5AC30000);
            chk("full data1023", wr_data[1023], 32'hA5C303FF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
